// File: rtl/phase_pkg.sv
// Shared phase encoding for the phase sequencer and its reset stretcher.
package phase_pkg;

  typedef enum logic [2:0] {
    StRstHold = 3'd0,
    StIdle    = 3'd1,
    StIf      = 3'd2,
    StRd      = 3'd3,
    StEx      = 3'd4,
    StMem     = 3'd5,
    StWb      = 3'd6
  } phase_e;

  localparam int unsigned DefaultResetHold = 4;

endpackage

// File: rtl/reset_stretch.sv
// Holds core_reset high for RESET_HOLD cycles after the system reset deasserts.
module reset_stretch
  import phase_pkg::*;
#(
  parameter int unsigned RESET_HOLD = DefaultResetHold
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic done_o,
  output logic core_reset_o
);

  localparam int unsigned CntW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(RESET_HOLD - 1);

  logic [CntW-1:0] hold_q, hold_d;
  logic            released_q, released_d;

  always_comb begin
    hold_d     = hold_q;
    released_d = released_q;
    if (!released_q) begin
      if (hold_q == HoldLast) begin
        released_d = 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q     <= '0;
      released_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      released_q <= released_d;
    end
  end

  assign done_o       = !released_q && (hold_q == HoldLast);
  assign core_reset_o = !released_q;

endmodule

// File: rtl/phase_sequencer.sv
// Per-phase enable sequencer (IF/RD/EX/MEM/WB) with run/halt/single-step and EX stall.
module phase_sequencer
  import phase_pkg::*;
#(
  parameter int unsigned RESET_HOLD = DefaultResetHold,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             stall,
  output logic             core_reset,
  output logic             imem_en,
  output logic             rf_rd_en,
  output logic             ex_en,
  output logic             dmem_en,
  output logic             rf_wr_en,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  phase_e           state_q, state_d;
  logic             halt_q, halt_d;
  logic             step_q;
  logic             step_flag_q, step_flag_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rst_done;
  logic             step_edge;

  reset_stretch #(
    .RESET_HOLD(RESET_HOLD)
  ) u_reset_stretch (
    .clk_i       (clock),
    .rst_i       (reset),
    .done_o      (rst_done),
    .core_reset_o(core_reset)
  );

  assign step_edge = step & ~step_q;

  always_comb begin
    state_d     = state_q;
    halt_d      = halt_q;
    step_flag_d = step_flag_q;
    count_d     = count_q;

    if (halt_req && (state_q != StRstHold) && (state_q != StIdle)) begin
      halt_d = 1'b1;
    end

    unique case (state_q)
      StRstHold: if (rst_done) state_d = StIdle;
      StIdle: begin
        halt_d = 1'b0;
        if (run) begin
          state_d = StIf;
        end else if (step_edge) begin
          state_d     = StIf;
          step_flag_d = 1'b1;
        end
      end
      StIf:  state_d = StRd;
      StRd:  state_d = StEx;
      StEx:  if (!stall) state_d = StMem;
      StMem: state_d = StWb;
      StWb: begin
        count_d = count_q + 1'b1;
        // halt_d already folds in a same-cycle halt_req
        if (halt_d || step_flag_q || !run) begin
          state_d     = StIdle;
          step_flag_d = 1'b0;
          halt_d      = 1'b0;
        end else begin
          state_d = StIf;
        end
      end
      default: state_d = StRstHold;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StRstHold;
      halt_q      <= 1'b0;
      step_q      <= 1'b0;
      step_flag_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      step_q      <= step;
      step_flag_q <= step_flag_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    imem_en  = 1'b0;
    rf_rd_en = 1'b0;
    ex_en    = 1'b0;
    dmem_en  = 1'b0;
    rf_wr_en = 1'b0;
    pc_en    = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      StIdle:  halted   = 1'b1;
      StIf:    imem_en  = 1'b1;
      StRd:    rf_rd_en = 1'b1;
      StEx:    ex_en    = 1'b1;
      StMem:   dmem_en  = 1'b1;
      StWb: begin
        rf_wr_en = 1'b1;
        pc_en    = 1'b1;
      end
      default: ;
    endcase
  end

  assign instr_count = count_q;

endmodule
